uart_boot_loader: RTL and testbench
===================================

Name: uart_boot_loader

Overview:
Program loader that sits directly upstream of the core's instruction memory and core reset. It receives a framed program image over an 8N1 UART, writes it word by word into instruction memory, and holds the core in reset until a load completes cleanly. When loading is disabled, the core runs from whatever the instruction memory already holds.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, UART bit rate; DIV = CLK_FREQ/BAUD (integer divide), must be >= 4.
ADDR_W, 32, instruction-memory byte-address width.
MAX_WORDS, 4096, largest accepted image in 32-bit words.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
uart_rx_i  in  1  serial input, asynchronous, idle high.
load_en_i  in  1  level; 1 = accept an image and hold core in reset.
rom_we_o  in/out: out  1  one-cycle write strobe to instruction memory.
rom_waddr_o  out  ADDR_W  byte address of the word being written (word-aligned).
rom_wdata_o  out  32  word being written.
core_rst_n_o  out  1  active-low reset to the core.
load_busy_o  out  1  frame reception in progress.
load_done_o  out  1  last load completed with a good checksum.
load_err_o  out  1  last load failed.

Behaviour:
- Reset values: rom_we_o=0, rom_waddr_o=0, rom_wdata_o=0, core_rst_n_o=0, busy/done/err=0. FSM is in IDLE; all counters are 0. Reset asserted mid-load aborts the load with no further writes.
- uart_rx_i is synchronised with 2 flops before any use.
- RX sub-block states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a falling edge enters R_START.
  - R_START: at DIV/2 cycles, the line is resampled. Low goes to R_DATA; high is a glitch and returns to R_IDLE.
  - R_DATA: 8 bits are sampled LSB first, each DIV cycles apart.
  - R_STOP: sampled after DIV cycles. High gives a one-cycle rx_valid with rx_byte. Low gives a one-cycle rx_ferr and no rx_valid.
  - Both outcomes return to R_IDLE.
- Frame format: 0xA5, LEN_lo, LEN_hi (LEN = word count), then LEN*4 data bytes with each word little-endian, then CSUM = XOR of all data bytes.
- Loader FSM states: IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: core_rst_n_o=1 when load_en_i=0. load_en_i=1 goes to SYNC, clears done/err, and drives core_rst_n_o=0 from the next cycle.
  - SYNC: bytes other than 0xA5 are discarded; 0xA5 goes to LEN0. busy=1 from SYNC through CSUM.
  - LEN0/LEN1: capture LEN. After LEN1, LEN==0 or LEN>MAX_WORDS goes to ERR; otherwise go to DATA.
  - DATA: bytes shift into a 4-byte assembler and XOR into the running checksum. On the 4th byte:
    - rom_we_o=1 for exactly one cycle on the cycle after that byte's rx_valid;
    - rom_waddr_o = word_idx*4 and rom_wdata_o = assembled word, both held until the next write;
    - word_idx increments. After word LEN-1 is written, go to CSUM.
  - CSUM: a match goes to DONE (done=1); a mismatch goes to ERR (err=1). Words already written are not rolled back.
  - DONE: core_rst_n_o=1 and done stays 1. load_en_i=0 goes to IDLE with done still 1.
  - ERR: core_rst_n_o=0 and err=1. load_en_i=0 goes to IDLE, which releases the core and keeps err=1.
- rx_ferr in any state SYNC..CSUM goes to ERR. In IDLE/DONE/ERR, received bytes and errors are ignored.
- load_en_i dropping in SYNC..CSUM aborts the load: go to ERR, then to IDLE on the next cycle because load_en_i is already 0.
- rx_valid cannot coincide with a write strobe. Bytes are spaced >= 10*DIV cycles apart and each write takes 1 cycle.
- word_idx is 16 bits wide and never wraps, because LEN<=MAX_WORDS is checked first.

Decomposition:
- Shared defines file: sync byte value 0xA5 and loader/RX state encodings.
- One sub-module, uart_rx: synchroniser, bit timing and 8N1 deframing. Its outputs are rx_valid, rx_byte[7:0] and rx_ferr.
- Loader FSM, assembler and checksum sit in uart_boot_loader.

Test Plan:
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10).
1. load_en=1, send A5 02 00 13 00 00 00 93 00 10 00 90 -> two rom_we_o pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. Then done=1, err=0, busy=0. core_rst_n_o is 0 throughout the frame and becomes 1 in DONE.
2. Same frame with CSUM=91 -> both writes occur, then err=1, core_rst_n_o stays 0. Dropping load_en -> IDLE, core_rst_n_o=1, err stays 1.
3. Send 00 FF, then the frame from test 1 -> bytes before A5 are ignored and the result is identical to test 1.
4. Byte with stop bit driven 0 during DATA -> err=1, no further rom_we_o. A 3-cycle low glitch on rx in SYNC -> no byte, state stays SYNC.
5. A5 00 00 -> err=1 with no writes. A5 01 10 (LEN=4097) -> err=1.
6. Assert rst_n=0 after the 5th data byte of test 1 -> all outputs return to reset values. After release, the full frame of test 1 loads correctly from word 0.

Source files
------------

// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader and its receiver.
package uart_boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling and deframing.
module uart_rx #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_ferr_o
);
  import uart_boot_loader_pkg::*;

  localparam int CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= R_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  // The start bit is rechecked at its midpoint; every later sample lands mid-bit too.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = sync2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d    = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
          state_d = R_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_valid_o = valid_q;
  assign rx_byte_o  = shift_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over UART, writes it into instruction memory
// and holds the core in reset until a load finishes with a good checksum.
module uart_boot_loader #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_i,
  input  logic              load_en_i,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              core_rst_n_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);
  import uart_boot_loader_pkg::*;

  localparam int DIV = CLK_FREQ / BAUD;

  logic       rxValid, rxFerr;
  logic [7:0] rxByte;

  uart_rx #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_i      (uart_rx_i),
    .rx_valid_o(rxValid),
    .rx_byte_o (rxByte),
    .rx_ferr_o (rxFerr)
  );

  ld_state_e         state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wordIdx_q, wordIdx_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              coreRstN_q, coreRstN_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       lenNew;

  assign lenNew = {rxByte, len_q[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wordIdx_q  <= '0;
      byteCnt_q  <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      coreRstN_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wordIdx_q  <= wordIdx_d;
      byteCnt_q  <= byteCnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      coreRstN_q <= coreRstN_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Abort (load_en dropped) beats a framing error, which beats byte handling.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wordIdx_d = wordIdx_q;
    byteCnt_d = byteCnt_q;
    word_d    = word_q;
    csum_d    = csum_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (load_en_i) begin
          state_d   = SYNC;
          done_d    = 1'b0;
          err_d     = 1'b0;
          len_d     = '0;
          wordIdx_d = '0;
          byteCnt_d = '0;
          csum_d    = '0;
        end
      end
      DONE, ERR: begin
        if (!load_en_i) state_d = IDLE;
      end
      default: begin
        if (!load_en_i || rxFerr) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (rxValid) begin
          unique case (state_q)
            SYNC: if (rxByte == SYNC_BYTE) state_d = LEN0;
            LEN0: begin
              len_d   = {8'd0, rxByte};
              state_d = LEN1;
            end
            LEN1: begin
              len_d = lenNew;
              if (lenNew == 16'd0 || {16'd0, lenNew} > 32'(MAX_WORDS)) begin
                state_d = ERR;
                err_d   = 1'b1;
              end else begin
                state_d = DATA;
              end
            end
            DATA: begin
              word_d    = {rxByte, word_q[31:8]};
              csum_d    = csum_q ^ rxByte;
              byteCnt_d = byteCnt_q + 2'd1;
              if (byteCnt_q == 2'd3) begin
                we_d      = 1'b1;
                waddr_d   = ADDR_W'({wordIdx_q, 2'b00});
                wdata_d   = word_d;
                wordIdx_d = wordIdx_q + 16'd1;
                if (wordIdx_q == len_q - 16'd1) state_d = CSUM;
              end
            end
            CSUM: begin
              if (rxByte == csum_q) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ERR;
                err_d   = 1'b1;
              end
            end
            default: state_d = ERR;
          endcase
        end
      end
    endcase
    coreRstN_d = (state_d == IDLE) || (state_d == DONE);
    busy_d     = (state_d == SYNC) || (state_d == LEN0) || (state_d == LEN1) ||
                 (state_d == DATA) || (state_d == CSUM);
  end

  assign rom_we_o     = we_q;
  assign rom_waddr_o  = waddr_q;
  assign rom_wdata_o  = wdata_q;
  assign core_rst_n_o = coreRstN_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table-driven frames plus hand-written
// glitch and mid-load reset sequences.
module tb_uart_boot_loader;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        load_en = 1'b0;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        core_rst_n;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  uart_boot_loader #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .ADDR_W   (32),
    .MAX_WORDS(4096)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx_i   (uart_rx),
    .load_en_i   (load_en),
    .rom_we_o    (rom_we),
    .rom_waddr_o (rom_waddr),
    .rom_wdata_o (rom_wdata),
    .core_rst_n_o(core_rst_n),
    .load_busy_o (load_busy),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] frame;
    int           nBytes;
    int           badStopIdx;
    int           expWrites;
    logic         expDone;
    logic         expErr;
    logic         expRstN;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] expAddr[2];
  logic [31:0] expData[2];
  logic [31:0] capAddr[8];
  logic [31:0] capData[8];
  int          wrCount;
  logic        rstLeak;
  int          nChecks = 0;
  int          nFails = 0;

  // Every negedge sample of the strobe counts as one write, so a stretched strobe shows up.
  always @(negedge clk) begin
    if (rom_we) begin
      if (wrCount < 8) begin
        capAddr[wrCount] = rom_waddr;
        capData[wrCount] = rom_wdata;
      end
      wrCount = wrCount + 1;
    end
    if (load_busy && core_rst_n) rstLeak = 1'b1;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic goodStop);
    uart_rx = 1'b0;
    waitCycles(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      waitCycles(DIV);
    end
    uart_rx = goodStop;
    waitCycles(DIV);
    uart_rx = 1'b1;
    waitCycles(2 * DIV);
  endtask

  task automatic applyStimulus(input logic [127:0] frame, input int n, input int badIdx);
    for (int i = 0; i < n; i++) sendByte(frame[127 - 8 * i -: 8], i != badIdx);
  endtask

  task automatic checkWrites(input string tag, input int n);
    checkOutput({tag, " writes"}, wrCount, n);
    for (int k = 0; k < n && k < 2; k++) begin
      checkOutput({tag, " waddr"}, capAddr[k], expAddr[k]);
      checkOutput({tag, " wdata"}, capData[k], expData[k]);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " we"}, {31'd0, rom_we}, 32'd0);
    checkOutput({tag, " waddr"}, rom_waddr, 32'd0);
    checkOutput({tag, " wdata"}, rom_wdata, 32'd0);
    checkOutput({tag, " core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
    checkOutput({tag, " busy"}, {31'd0, load_busy}, 32'd0);
    checkOutput({tag, " done"}, {31'd0, load_done}, 32'd0);
    checkOutput({tag, " err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    logic [127:0] goodFrame;
    goodFrame = 128'hA5020013_00000093_00100090_00000000;
    vecs[0] = '{goodFrame, 12, -1, 2, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{128'hA5020013_00000093_00100091_00000000, 12, -1, 2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{128'h00FFA502_00130000_00930010_00900000, 14, -1, 2, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{goodFrame, 12, 5, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{{24'hA50000, 104'd0}, 3, -1, 0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{{24'hA50110, 104'd0}, 3, -1, 0, 1'b0, 1'b1, 1'b0};
    expAddr[0] = 32'h0;
    expData[0] = 32'h00000013;
    expAddr[1] = 32'h4;
    expData[1] = 32'h00100093;
    wrCount = 0;
    rstLeak = 1'b0;

    waitCycles(4);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    waitCycles(4);
    checkOutput("idle core_rst_n", {31'd0, core_rst_n}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      load_en = 1'b0;
      waitCycles(5);
      wrCount = 0;
      rstLeak = 1'b0;
      load_en = 1'b1;
      waitCycles(3);
      applyStimulus(vecs[v].frame, vecs[v].nBytes, vecs[v].badStopIdx);
      waitCycles(5);
      checkWrites($sformatf("vec%0d", v), vecs[v].expWrites);
      checkOutput($sformatf("vec%0d done", v), {31'd0, load_done}, {31'd0, vecs[v].expDone});
      checkOutput($sformatf("vec%0d err", v), {31'd0, load_err}, {31'd0, vecs[v].expErr});
      checkOutput($sformatf("vec%0d busy", v), {31'd0, load_busy}, 32'd0);
      checkOutput($sformatf("vec%0d core_rst_n", v), {31'd0, core_rst_n}, {31'd0, vecs[v].expRstN});
      checkOutput($sformatf("vec%0d core held", v), {31'd0, rstLeak}, 32'd0);
      load_en = 1'b0;
      waitCycles(5);
      checkOutput($sformatf("vec%0d released", v), {31'd0, core_rst_n}, 32'd1);
      checkOutput($sformatf("vec%0d done kept", v), {31'd0, load_done}, {31'd0, vecs[v].expDone});
      checkOutput($sformatf("vec%0d err kept", v), {31'd0, load_err}, {31'd0, vecs[v].expErr});
    end

    // A short low pulse in SYNC must not produce a byte; the real frame then loads.
    wrCount = 0;
    load_en = 1'b1;
    waitCycles(3);
    uart_rx = 1'b0;
    waitCycles(3);
    uart_rx = 1'b1;
    waitCycles(4 * DIV);
    checkOutput("glitch busy", {31'd0, load_busy}, 32'd1);
    checkOutput("glitch err", {31'd0, load_err}, 32'd0);
    checkOutput("glitch writes", wrCount, 32'd0);
    applyStimulus(goodFrame, 12, -1);
    waitCycles(5);
    checkWrites("post-glitch", 2);
    checkOutput("post-glitch done", {31'd0, load_done}, 32'd1);

    // Reset after the fifth data byte aborts; the reload starts again at word 0.
    load_en = 1'b0;
    waitCycles(5);
    wrCount = 0;
    load_en = 1'b1;
    waitCycles(3);
    applyStimulus(goodFrame, 8, -1);
    waitCycles(2);
    checkOutput("midload writes", wrCount, 32'd1);
    rst_n = 1'b0;
    waitCycles(2);
    checkResetOutputs("midload reset");
    wrCount = 0;
    rst_n = 1'b1;
    waitCycles(3);
    applyStimulus(goodFrame, 12, -1);
    waitCycles(5);
    checkWrites("reload", 2);
    checkOutput("reload done", {31'd0, load_done}, 32'd1);
    checkOutput("reload err", {31'd0, load_err}, 32'd0);
    checkOutput("reload core_rst_n", {31'd0, core_rst_n}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
